// File: rtl/reg_xfer_arbiter.sv
// Round-robin arbiter and sequencer for register-to-register moves on the shared
// register-file bus. One move at a time: read the source onto the bus, latch the word,
// then write it into the destination. Self-moves skip the write phase.
module reg_xfer_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IW = $clog2(NREGS),
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IW-1:0]   req_src,
  input  logic [NREQ*IW-1:0]   req_dst,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [NREGS-1:0]     sel_n,
  output logic                 we_n,
  input  logic [WIDTH-1:0]     bus_in,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 bus_oe
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic [GW-1:0]    pick;
  logic             any_req;
  logic [IW-1:0]    src_q, src_d;
  logic [IW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  // Pick the first requester at or after rr_q, wrapping; walk downward so the
  // smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    pick    = rr_q;
    any_req = 1'b0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req[(int'(rr_q) + k) % int'(NREQ)]) begin
        pick    = GW'((int'(rr_q) + k) % int'(NREQ));
        any_req = 1'b1;
      end
    end
  end

  // Next-state: requests and indices are only sampled in idle.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d   = pick;
          src_d   = req_src[int'(pick)*IW +: IW];
          dst_d   = req_dst[int'(pick)*IW +: IW];
          state_d = StRd;
        end
      end
      StRd: begin
        hold_d  = bus_in;
        state_d = (src_q == dst_q) ? StDone : StWr;
      end
      StWr: begin
        state_d = StDone;
      end
      StDone: begin
        rr_d    = (int'(gnt_q) == int'(NREQ) - 1) ? '0 : gnt_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no input reaches an output.
  always_comb begin
    ack     = '0;
    busy    = (state_q != StIdle);
    sel_n   = '1;
    we_n    = 1'b1;
    bus_oe  = 1'b0;
    bus_out = '0;
    unique case (state_q)
      StRd: begin
        sel_n[src_q] = 1'b0;
      end
      StWr: begin
        sel_n[dst_q] = 1'b0;
        we_n         = 1'b0;
        bus_oe       = 1'b1;
        bus_out      = hold_q;
      end
      StDone: begin
        ack[gnt_q] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State register with synchronous reset; reset discards any move in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      gnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: doc/reg_xfer_arbiter.md
# reg_xfer_arbiter

Round-robin arbiter and sequencer for the shared register-file bus. It accepts register-to-register move requests from up to NREQ requesters and grants one at a time. For each granted move it drives the active-low `sel_n`/`we_n` strobes: first the source register drives the shared bus, then the captured word is written into the destination register. It sits between the requesting units and the bank of `register` instances, and is the only block allowed to assert their strobes.

## Interface
- `WIDTH`, 16: data width of the bus and registers.
- `NREGS`, 8: number of registers on the bus. Must be a power of two, ≥2. `IW = log2(NREGS)`.
- `NREQ`, 4: number of requesters, ≥1.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: per-requester move request. Held high until the matching `ack`.
- `req_src` input NREQ*IW: source index; requester i uses bits [i*IW +: IW].
- `req_dst` input NREQ*IW: destination index, same packing as `req_src`.
- `ack` output NREQ: one-cycle completion pulse to the granted requester.
- `busy` output 1: high in any state other than IDLE.
- `sel_n` output NREGS: active-low register selects, at most one low.
- `we_n` output 1: active-low write enable shared by all registers.
- `bus_in` input WIDTH: resolved shared bus value, sampled by this block.
- `bus_out` output WIDTH: value this block drives onto the bus.
- `bus_oe` output 1: high when `bus_out` must drive the bus.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - If any `req` bit is high, grant the first set bit at or after `rr_ptr`, searching upward with wrap-around.
  - Latch `gnt_id`, plus `src` and `dst` from that requester's slice.
  - Go to RD. Otherwise stay in IDLE.
- RD:
  - `sel_n[src]`=0, `we_n`=1, `bus_oe`=0, so the source register drives the bus.
  - At the closing edge, `hold` <= `bus_in`.
  - Go to DONE if `src`==`dst`, else go to WR.
- WR:
  - `sel_n[dst]`=0, `we_n`=0, `bus_oe`=1, `bus_out`=`hold`.
  - The destination register captures the word at the closing edge.
  - Go to DONE.
- DONE:
  - `ack[gnt_id]`=1.
  - `rr_ptr` <= (`gnt_id`+1) mod NREQ.
  - Go to IDLE.
- All strobe outputs are decoded from the registered state, `src`, `dst`, `gnt_id` and `hold` only. There is no combinational path from `req`, `req_src`, `req_dst` or `bus_in` to any output.
- Outside RD and WR: `sel_n` all ones, `we_n`=1, `bus_oe`=0, `bus_out`=0.
- Requests and indices are sampled only in IDLE. Changes to `req`, `req_src` or `req_dst` during RD, WR or DONE have no effect.
- A requester dropping `req` before `ack` does not abort the move. The transfer completes and `ack` still pulses.
- Self-move (`src`==`dst`) performs no write, so the register is unchanged.

## Timing
- Reset state (applies at any cycle, including mid-transfer):
  - State IDLE; `rr_ptr`=0; `hold`=0.
  - `ack`=0; `busy`=0; `sel_n` all ones; `we_n`=1; `bus_oe`=0; `bus_out`=0.
  - An aborted transfer is never acked, and no write strobe occurs in the cycle after reset.
- Latency, with `req` seen high in IDLE at cycle t:
  - Move: RD in t+1, WR in t+2, `ack` in t+3. Next grant possible at t+5, since t+4 is IDLE.
  - Self-move: RD in t+1, `ack` in t+2.
- Throughput: one move per 4 cycles; one self-move per 3 cycles.
- The requester must deassert `req`, or present a new move, by the edge following `ack`. A `req` still high in the next IDLE is treated as a new request.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Simultaneous requests in IDLE: the lowest index at or above `rr_ptr` wins.

## Test plan
- After reset, assert `rst` for 1 cycle. All outputs must take the reset values; then drive a single move, requester 0, src=2, dst=5, reg2=0xBEEF. Required response:
  - `sel_n`=8'b1111_1011 with `we_n`=1 in t+1.
  - `sel_n`=8'b1101_1111, `we_n`=0, `bus_out`=0xBEEF, `bus_oe`=1 in t+2.
  - `ack`=4'b0001 in t+3; reg5 reads 0xBEEF afterwards.
- Self-move: requester 1, src=dst=3. Required: only RD occurs, `we_n` stays 1 throughout, `ack[1]` in t+2, reg3 unchanged.
- Round robin: hold `req`=4'b1111 with requesters re-asserting after each ack. Grant order must be 0,1,2,3,0; each ack is spaced 4 cycles apart, plus one IDLE cycle between moves.
- Pointer wrap: `rr_ptr`=3 with `req`=4'b1001. Requester 3 is granted first, then requester 0.
- Reset mid-transfer: assert `rst` in the WR cycle. The next cycle must show `sel_n` all ones, `we_n`=1, `ack`=0, `busy`=0. No ack is ever issued for the aborted move, and the next grant starts from requester 0.
- Request drop and index change: requester 2 drops `req` and changes `req_dst` in RD. The write still targets the originally latched dst, and `ack[2]` still pulses in t+3.
